fpadd_iter: RTL

Iterative, parametrised IEEE-754 adder/subtractor that succeeds the combinational `fpadd` datapath for area-constrained use. A multi-cycle FSM performs unpack, bit-serial alignment, add, bit-serial normalisation and rounding, so one shifter-free datapath serves binary32 or binary64. It supports add and subtract, four rounding modes and full exception flags. It sits behind a valid/ready request port and holds its result until the consumer accepts it.

---
 rtl/fpadd_iter_if.sv | 30 +++
 rtl/fpadd_iter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_iter_if.sv
// fpadd_iter_if: request/result handshake bundle for the iterative FP adder.
// master = requester/consumer side, slave = the adder.
interface fpadd_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [2:0]   rm;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         busy;

  modport master (
    output start_valid, op1, op2, rm, sub, res_ready,
    input  start_ready, res_valid, result, flags, busy
  );

  modport slave (
    input  start_valid, op1, op2, rm, sub, res_ready,
    output start_ready, res_valid, result, flags, busy
  );
endinterface

// File: rtl/fpadd_iter.sv
// fpadd_iter: multi-cycle IEEE-754 add/subtract with bit-serial align/normalise.
// Flags are {NV, DZ, OF, UF, NX}; DZ is always 0.
// Define FPADD_ITER_DENORM_EN for subnormal support; default flushes to zero.
module fpadd_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic clk,
  input  logic reset,
  fpadd_iter_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // hidden bit + fraction + guard/round/sticky
  localparam int EW = EXP_W + 1;   // headroom for carry and round-up
  localparam logic [EW-1:0] EMIN  = EW'(1);
  localparam logic [EW-1:0] EMIN1 = EW'(2);
  localparam logic [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0] SHMAX = EW'(MAN_W + 3);
  localparam logic [1:0] RM_RNE = 2'd0, RM_RZ = 2'd1, RM_RUP = 2'd2, RM_RDN = 2'd3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_n;

  logic [W-1:0]  op_a, op_b, result_q;
  logic [4:0]    flags_q;
  logic [1:0]    rm_q;
  logic [SW-1:0] sa, sb;
  logic          sgn_a, sgn_b;
  logic [EW-1:0] e, cnt;

  // Operand classification on the registered operands
  logic s1, s2;
  logic [EXP_W-1:0] x1, x2;
  logic [MAN_W-1:0] f1, f2;
  logic nan1, nan2, snan1, snan2, inf1, inf2, zero1, zero2;
  assign {s1, x1, f1} = op_a;
  assign {s2, x2, f2} = op_b;
  assign nan1  = (&x1) & (|f1);
  assign nan2  = (&x2) & (|f2);
  assign snan1 = nan1 & ~f1[MAN_W-1];
  assign snan2 = nan2 & ~f2[MAN_W-1];
  assign inf1  = (&x1) & ~(|f1);
  assign inf2  = (&x2) & ~(|f2);
`ifdef FPADD_ITER_DENORM_EN
  assign zero1 = ~(|x1) & ~(|f1);
  assign zero2 = ~(|x2) & ~(|f2);
`else
  assign zero1 = ~(|x1);
  assign zero2 = ~(|x2);
`endif

  // Subnormals sit at the minimum exponent with a zero hidden bit
  logic [EW-1:0] e1, e2, d;
  logic [SW-1:0] m1, m2;
  logic          swap;
  assign e1   = (|x1) ? {1'b0, x1} : EMIN;
  assign e2   = (|x2) ? {1'b0, x2} : EMIN;
  assign m1   = {|x1, f1, 3'b000};
  assign m2   = {|x2, f2, 3'b000};
  assign swap = e2 > e1;
  assign d    = swap ? e2 - e1 : e1 - e2;

  // Special-operand results resolved in UNPACK
  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_fl;
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_fl  = '0;
    if (snan1 | snan2 | (inf1 & inf2 & (s1 != s2))) begin
      spec_res = QNAN;
      spec_fl  = 5'b10000;
    end else if (nan1 | nan2) spec_res = QNAN;
    else if (inf1) spec_res = op_a;
    else if (inf2) spec_res = op_b;
    else if (zero1 & zero2)
      spec_res = {(s1 == s2) ? s1 : (rm_q == RM_RDN), {(W-1){1'b0}}};
    else if (zero1) spec_res = op_b;
    else if (zero2) spec_res = op_a;
    else spec_hit = 1'b0;
  end

  // Signed-magnitude add; sa/sb hold the larger-exponent operand first
  logic          eff_sub, a_ge, sum_sign;
  logic [SW:0]   sum;
  assign eff_sub  = sgn_a ^ sgn_b;
  assign a_ge     = sa >= sb;
  assign sum      = !eff_sub ? {1'b0, sa} + {1'b0, sb}
                  : (a_ge ? {1'b0, sa} - {1'b0, sb} : {1'b0, sb} - {1'b0, sa});
  assign sum_sign = (eff_sub & ~a_ge) ? sgn_b : sgn_a;

  // Rounding increment from guard/round/sticky
  logic inexact, inc, tiny;
  logic [MAN_W+1:0] m_inc;
  logic [EW-1:0]    e_r;
  assign inexact = |sa[2:0];
  assign tiny    = ~sa[SW-1];
  always_comb begin
    case (rm_q)
      RM_RNE:  inc = sa[2] & (sa[1] | sa[0] | sa[3]);
      RM_RZ:   inc = 1'b0;
      RM_RUP:  inc = ~sgn_a & inexact;
      default: inc = sgn_a & inexact;
    endcase
  end
  assign m_inc = {1'b0, sa[SW-1:3]} + (MAN_W+2)'(inc);
  assign e_r   = e + EW'(m_inc[MAN_W+1]);

  // Final packing: exact zero, overflow, tiny, or normal/subnormal result
  logic [W-1:0] rnd_res, inf_r, max_r;
  logic [4:0]   rnd_fl;
  assign inf_r = {sgn_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_r = {sgn_a, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  always_comb begin
    rnd_res = {sgn_a, (m_inc[MAN_W+1] | m_inc[MAN_W]) ? e_r[EXP_W-1:0] : {EXP_W{1'b0}},
               m_inc[MAN_W-1:0]};
    rnd_fl  = {3'b000, tiny & inexact, inexact};
    if (~(|sa)) begin
      rnd_res = {rm_q == RM_RDN, {(W-1){1'b0}}};
      rnd_fl  = '0;
    end else if (e_r >= EMAX) begin
      rnd_fl = 5'b00101;
      case (rm_q)
        RM_RZ:   rnd_res = max_r;
        RM_RUP:  rnd_res = sgn_a ? max_r : inf_r;
        RM_RDN:  rnd_res = sgn_a ? inf_r : max_r;
        default: rnd_res = inf_r;
      endcase
    end
`ifndef FPADD_ITER_DENORM_EN
    else if (tiny) begin
      rnd_res = {sgn_a, {(W-1){1'b0}}};
      rnd_fl  = 5'b00011;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (bus.start_valid) state_n = UNPACK;
      UNPACK: state_n = spec_hit ? DONE : ((d != '0) ? ALIGN : ADD);
      ALIGN:  if (cnt > SHMAX || cnt == EW'(1)) state_n = ADD;
      ADD:    state_n = (!sum[SW] && !sum[SW-1] && (|sum) && e > EMIN) ? NORM : ROUND;
      NORM:   if (sa[SW-2] || e == EMIN1) state_n = ROUND;
      ROUND:  state_n = DONE;
      DONE:   if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers, one step per state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a <= '0; op_b <= '0; rm_q <= '0;
      sa <= '0; sb <= '0; sgn_a <= 1'b0; sgn_b <= 1'b0;
      e <= '0; cnt <= '0; result_q <= '0; flags_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_valid) begin
          op_a <= bus.op1;
          op_b <= {bus.op2[W-1] ^ bus.sub, bus.op2[W-2:0]};
          rm_q <= bus.rm[2] ? RM_RNE : bus.rm[1:0];
        end
        UNPACK: begin
          if (spec_hit) begin
            result_q <= spec_res;
            flags_q  <= spec_fl;
          end else begin
            sa    <= swap ? m2 : m1;
            sb    <= swap ? m1 : m2;
            sgn_a <= swap ? s2 : s1;
            sgn_b <= swap ? s1 : s2;
            e     <= swap ? e2 : e1;
            cnt   <= d;
          end
        end
        ALIGN: begin
          // Beyond the guard/round/sticky reach only the sticky survives
          if (cnt > SHMAX) sb <= {{(SW-1){1'b0}}, |sb};
          else begin
            sb  <= {1'b0, sb[SW-1:2], |sb[1:0]};
            cnt <= cnt - EW'(1);
          end
        end
        ADD: begin
          sgn_a <= sum_sign;
          if (sum[SW]) begin
            sa <= {sum[SW:2], |sum[1:0]};
            e  <= e + EW'(1);
          end else sa <= sum[SW-1:0];
        end
        NORM: begin
          sa <= {sa[SW-2:0], 1'b0};
          e  <= e - EW'(1);
        end
        ROUND: begin
          result_q <= rnd_res;
          flags_q  <= rnd_fl;
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE) & reset;
  assign bus.busy        = (state != IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.result      = result_q;
  assign bus.flags       = flags_q;
endmodule
